// File: rtl/parking_quota_controller.sv
// Two-class (uni/guest) parking occupancy tracker with a time-scheduled guest quota
// and a registered request/acknowledge result for every entry and exit event.
module parking_quota_controller #(
    parameter int              CNT_W           = 10,
    parameter int              TOTAL_CAP       = 700,
    parameter int              UNI_CAP         = 500,
    parameter int              GUEST_BASE      = 200,
    parameter int              GUEST_STEP      = 50,
    parameter int              GUEST_MAX       = 500,
    parameter int              NUM_PHASES      = 5,
    parameter int              TIME_W          = 40,
    parameter longint unsigned FIRST_PHASE_CYC = 64'd720_000_000_000,
    parameter longint unsigned PHASE_CYC       = 64'd360_000_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             entry_uni,
    input  logic             exit_req,
    input  logic             exit_uni,
    output logic             entry_ack,
    output logic             entry_grant,
    output logic             exit_ack,
    output logic             exit_err,
    output logic [CNT_W-1:0] uni_parked,
    output logic [CNT_W-1:0] guest_parked,
    output logic [CNT_W-1:0] uni_free,
    output logic [CNT_W-1:0] guest_free,
    output logic             uni_avail,
    output logic             guest_avail,
    output logic [CNT_W-1:0] guest_quota,
    output logic [2:0]       phase
);

    localparam int                SUM_W     = CNT_W + 1;
    localparam logic [CNT_W-1:0]  UNI_CAP_C = CNT_W'(UNI_CAP);
    localparam logic [SUM_W-1:0]  TOTAL_C   = SUM_W'(TOTAL_CAP);
    localparam logic [2:0]        LAST_PH   = 3'(NUM_PHASES - 1);
    localparam logic [TIME_W-1:0] FIRST_M1  = TIME_W'(FIRST_PHASE_CYC - 64'd1);
    localparam logic [TIME_W-1:0] STEP_M1   = TIME_W'(PHASE_CYC - 64'd1);
    localparam logic [CNT_W-1:0]  UFREE_RST = CNT_W'((UNI_CAP < TOTAL_CAP) ? UNI_CAP : TOTAL_CAP);
    localparam logic [CNT_W-1:0]  GFREE_RST = CNT_W'((GUEST_BASE < TOTAL_CAP) ? GUEST_BASE : TOTAL_CAP);

    function automatic logic [CNT_W-1:0] min_cnt(input logic [SUM_W-1:0] a,
                                                 input logic [SUM_W-1:0] b);
        logic [SUM_W-1:0] m;
        m = (a < b) ? a : b;
        return CNT_W'(m);
    endfunction

    function automatic logic [CNT_W-1:0] quota_of(input logic [2:0] ph);
        if (ph >= LAST_PH) return CNT_W'(GUEST_MAX);
        return CNT_W'(GUEST_BASE + int'(ph) * GUEST_STEP);
    endfunction

    logic [TIME_W-1:0] elapsed_q, elapsed_d, tmr_q, tmr_d;
    logic [2:0]        phase_q, phase_d;
    logic [CNT_W-1:0]  quota_q, quota_d;
    logic [CNT_W-1:0]  uni_q, uni_d, guest_q, guest_d, uni_x, guest_x;
    logic [CNT_W-1:0]  ufree_q, ufree_d, gfree_q, gfree_d, gheadroom;
    logic [SUM_W-1:0]  total_x, total_d;
    logic              eack_q, grant_q, grant_d, xack_q, err_q, err_d;

    // Phase timing: phase 1 starts when elapsed reaches FIRST_PHASE_CYC, later phases every PHASE_CYC
    always_comb begin
        elapsed_d = (&elapsed_q) ? elapsed_q : elapsed_q + TIME_W'(1);
        phase_d   = phase_q;
        tmr_d     = tmr_q;
        if (phase_q < LAST_PH) begin
            if (phase_q == 3'd0) begin
                if (elapsed_q == FIRST_M1) begin
                    phase_d = 3'd1;
                    tmr_d   = '0;
                end
            end else if (tmr_q == STEP_M1) begin
                phase_d = phase_q + 3'd1;
                tmr_d   = '0;
            end else begin
                tmr_d = tmr_q + TIME_W'(1);
            end
        end
        quota_d = quota_of(phase_q);
    end

    // Exit first against current counts, then entry against post-exit counts
    always_comb begin
        uni_x   = uni_q;
        guest_x = guest_q;
        err_d   = 1'b0;
        if (exit_req) begin
            if (exit_uni) begin
                if (uni_q != '0) uni_x = uni_q - CNT_W'(1);
                else             err_d = 1'b1;
            end else begin
                if (guest_q != '0) guest_x = guest_q - CNT_W'(1);
                else               err_d   = 1'b1;
            end
        end
        total_x = {1'b0, uni_x} + {1'b0, guest_x};

        grant_d = 1'b0;
        if (entry_req) begin
            if (entry_uni) grant_d = (uni_x < UNI_CAP_C) && (total_x < TOTAL_C);
            else           grant_d = (guest_x < quota_q) && (total_x < TOTAL_C);
        end

        uni_d   = uni_x;
        guest_d = guest_x;
        if (grant_d) begin
            if (entry_uni) uni_d   = uni_x + CNT_W'(1);
            else           guest_d = guest_x + CNT_W'(1);
        end
        total_d = {1'b0, uni_d} + {1'b0, guest_d};

        // Free space is judged against the quota that becomes visible together with the counts
        gheadroom = (guest_d >= quota_d) ? '0 : quota_d - guest_d;
        ufree_d   = min_cnt({1'b0, UNI_CAP_C - uni_d}, TOTAL_C - total_d);
        gfree_d   = min_cnt({1'b0, gheadroom}, TOTAL_C - total_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            elapsed_q <= '0;
            tmr_q     <= '0;
            phase_q   <= 3'd0;
            quota_q   <= CNT_W'(GUEST_BASE);
            uni_q     <= '0;
            guest_q   <= '0;
            ufree_q   <= UFREE_RST;
            gfree_q   <= GFREE_RST;
            eack_q    <= 1'b0;
            grant_q   <= 1'b0;
            xack_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            elapsed_q <= elapsed_d;
            tmr_q     <= tmr_d;
            phase_q   <= phase_d;
            quota_q   <= quota_d;
            uni_q     <= uni_d;
            guest_q   <= guest_d;
            ufree_q   <= ufree_d;
            gfree_q   <= gfree_d;
            eack_q    <= entry_req;
            grant_q   <= grant_d;
            xack_q    <= exit_req;
            err_q     <= err_d;
        end
    end

    assign entry_ack    = eack_q;
    assign entry_grant  = grant_q;
    assign exit_ack     = xack_q;
    assign exit_err     = err_q;
    assign uni_parked   = uni_q;
    assign guest_parked = guest_q;
    assign uni_free     = ufree_q;
    assign guest_free   = gfree_q;
    assign uni_avail    = (ufree_q != '0);
    assign guest_avail  = (gfree_q != '0);
    assign guest_quota  = quota_q;
    assign phase        = phase_q;

endmodule

// File: tb/tb_parking_quota_controller.sv
// Randomised and directed bench for parking_quota_controller against a counting reference model.
module tb_parking_quota_controller;

    localparam int     CNT_W      = 10;
    localparam int     TOTAL_CAP  = 700;
    localparam int     UNI_CAP    = 500;
    localparam int     GUEST_BASE = 200;
    localparam int     GUEST_STEP = 50;
    localparam int     GUEST_MAX  = 500;
    localparam int     NUM_PH     = 5;
    localparam longint FIRST_CYC  = 1500;
    localparam longint STEP_CYC   = 200;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             entry_req = 1'b0, entry_uni = 1'b0, exit_req = 1'b0, exit_uni = 1'b0;
    logic             entry_ack, entry_grant, exit_ack, exit_err, uni_avail, guest_avail;
    logic [CNT_W-1:0] uni_parked, guest_parked, uni_free, guest_free, guest_quota;
    logic [2:0]       phase;

    parking_quota_controller #(
        .CNT_W(CNT_W), .TOTAL_CAP(TOTAL_CAP), .UNI_CAP(UNI_CAP), .GUEST_BASE(GUEST_BASE),
        .GUEST_STEP(GUEST_STEP), .GUEST_MAX(GUEST_MAX), .NUM_PHASES(NUM_PH), .TIME_W(40),
        .FIRST_PHASE_CYC(64'd1500), .PHASE_CYC(64'd200)
    ) dut (
        .clk(clk), .reset(reset),
        .entry_req(entry_req), .entry_uni(entry_uni), .exit_req(exit_req), .exit_uni(exit_uni),
        .entry_ack(entry_ack), .entry_grant(entry_grant), .exit_ack(exit_ack), .exit_err(exit_err),
        .uni_parked(uni_parked), .guest_parked(guest_parked), .uni_free(uni_free),
        .guest_free(guest_free), .uni_avail(uni_avail), .guest_avail(guest_avail),
        .guest_quota(guest_quota), .phase(phase)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     failures = 0;
    int     m_uni, m_guest;
    longint m_cyc;
    bit     m_grant, m_err;
    int     late_guest_grants;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ph_at(input longint t);
        longint p;
        if (t < FIRST_CYC) return 0;
        p = 1 + (t - FIRST_CYC) / STEP_CYC;
        return (p > NUM_PH - 1) ? NUM_PH - 1 : int'(p);
    endfunction

    function automatic int quota_for(input int p);
        return (p == NUM_PH - 1) ? GUEST_MAX : GUEST_BASE + p * GUEST_STEP;
    endfunction

    // Quota visible while elapsed == t: it trails the phase by one cycle
    function automatic int vis_quota(input longint t);
        return (t == 0) ? GUEST_BASE : quota_for(ph_at(t - 1));
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check_all(input bit ereq, input bit xreq);
        int q, room, uf, gf;
        q    = vis_quota(m_cyc);
        room = TOTAL_CAP - m_uni - m_guest;
        uf   = imin(UNI_CAP - m_uni, room);
        gf   = imin((q > m_guest) ? q - m_guest : 0, room);
        chk("entry_ack", int'(entry_ack), int'(ereq));
        if (ereq) chk("entry_grant", int'(entry_grant), int'(m_grant));
        chk("exit_ack", int'(exit_ack), int'(xreq));
        if (xreq) chk("exit_err", int'(exit_err), int'(m_err));
        chk("uni_parked", int'(uni_parked), m_uni);
        chk("guest_parked", int'(guest_parked), m_guest);
        chk("uni_free", int'(uni_free), uf);
        chk("guest_free", int'(guest_free), gf);
        chk("uni_avail", int'(uni_avail), int'(uf != 0));
        chk("guest_avail", int'(guest_avail), int'(gf != 0));
        chk("guest_quota", int'(guest_quota), q);
        chk("phase", int'(phase), ph_at(m_cyc));
    endtask

    task automatic step(input bit ereq, input bit euni, input bit xreq, input bit xuni);
        int q_used;
        entry_req = ereq; entry_uni = euni; exit_req = xreq; exit_uni = xuni;
        @(posedge clk);
        q_used  = vis_quota(m_cyc);
        m_err   = 1'b0;
        m_grant = 1'b0;
        if (xreq) begin
            if (xuni) begin
                if (m_uni > 0) m_uni--; else m_err = 1'b1;
            end else begin
                if (m_guest > 0) m_guest--; else m_err = 1'b1;
            end
        end
        if (ereq) begin
            if (m_uni + m_guest < TOTAL_CAP) begin
                if (euni && m_uni < UNI_CAP) begin m_uni++; m_grant = 1'b1; end
                else if (!euni && m_guest < q_used) begin m_guest++; m_grant = 1'b1; end
            end
        end
        m_cyc++;
        #1;
        check_all(ereq, xreq);
        @(negedge clk);
        entry_req = 1'b0; exit_req = 1'b0;
        entry_uni = $urandom_range(0, 1); exit_uni = $urandom_range(0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        entry_req = 1'b0; exit_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_uni = 0; m_guest = 0; m_cyc = 0;
        #1;
        check_all(1'b0, 1'b0);
    endtask

    initial begin
        m_uni = 0; m_guest = 0; m_cyc = 0; late_guest_grants = 0;

        // Reset state and first admissions
        do_reset();
        chk("rst_uni_free", int'(uni_free), 500);
        chk("rst_guest_free", int'(guest_free), 200);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("five_uni_free", int'(uni_free), 497);
        chk("five_guest_free", int'(guest_free), 198);

        // Guest quota boundary in phase 0
        repeat (198) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("g201_grant", int'(entry_grant), 0);
        chk("g201_avail", int'(guest_avail), 0);
        chk("g201_parked", int'(guest_parked), 200);

        // Random traffic spanning the phase boundaries
        for (int i = 0; i < 2400; i++)
            step($urandom_range(0, 9) < 8, $urandom_range(0, 1),
                 $urandom_range(0, 9) < 3, $urandom_range(0, 1));

        // Full lot: same-class swap, then uni exit with guest entry
        do_reset();
        repeat (500) step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (200) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("full_uni_free", int'(uni_free), 0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("swap_grant", int'(entry_grant), 1);
        chk("swap_uni", int'(uni_parked), 500);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("mix_err", int'(exit_err), 0);
        chk("mix_grant", int'(entry_grant), 0);
        chk("mix_uni", int'(uni_parked), 499);
        chk("mix_guest", int'(guest_parked), 200);

        // Exit from an empty class
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("empty_exit_err", int'(exit_err), 1);
        step(1'b0, 1'b0, 1'b1, 1'b1);

        // Phase stepping with the guest class full
        do_reset();
        repeat (200) step(1'b1, 1'b0, 1'b0, 1'b0);
        while (m_cyc < FIRST_CYC + 4 * STEP_CYC + 100) begin
            step($urandom_range(0, 1), 1'b0, $urandom_range(0, 9) == 0, 1'b1);
            if (phase != 3'd0 && entry_ack && entry_grant) late_guest_grants++;
        end
        chk("guest_regranted", int'(late_guest_grants > 0), 1);
        chk("final_phase", int'(phase), 4);
        chk("final_quota", int'(guest_quota), 500);

        // Reset in the middle of an entry acknowledge
        do_reset();
        repeat (9) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_ack", int'(entry_ack), 1);
        chk("pre_rst_uni", int'(uni_parked), 10);
        reset = 1'b1;
        #1;
        m_uni = 0; m_guest = 0; m_cyc = 0;
        check_all(1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_ack", int'(entry_ack), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
